// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - FIFO of outstanding branch predictions resolved in order into predictor updates
// Optional misprediction counter enabled by defining BRU_MISPREDICT_COUNT_EN.
module branch_resolve_unit #(
  parameter int ADDR_W = 1,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [ADDR_W-1:0]        pred_addr,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     upd_valid,
  output logic [ADDR_W-1:0]        upd_address,
  output logic                     upd_result,
  output logic                     mispredict,
  output logic                     res_error,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic [CNT_W-1:0]         mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  // Each entry packs {address, predicted direction}.
  logic [ADDR_W:0]     mem_q [DEPTH];
  logic [ADDR_W:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    count_q, count_d;
  logic                upd_valid_q, upd_valid_d;
  logic [ADDR_W-1:0]   upd_address_q, upd_address_d;
  logic                upd_result_q, upd_result_d;
  logic                mispredict_q, mispredict_d;
  logic                res_error_q, res_error_d;

  logic                full;
  logic                push;
  logic                pop;
  logic                empty_resolve;
  logic [ADDR_W:0]     head;
  logic                head_wrong;

  // Ready depends only on registered occupancy; a same-cycle pop never frees a slot early.
  assign full          = (count_q == FULL_CNT);
  assign pred_ready    = !full;
  assign push          = pred_valid && pred_ready && !flush;
  assign pop           = res_valid && (count_q != '0) && !flush;
  assign empty_resolve = res_valid && (count_q == '0) && !flush;
  assign head          = mem_q[rd_ptr_q];
  assign head_wrong    = (head[0] != res_taken);

  // Queue storage write; contents are don't-care until pushed so no reset needed.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = {pred_addr, pred_taken};
    end
  end

  // Pointer, occupancy and update-strobe next state; flush empties the queue and masks everything else.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    upd_valid_d   = 1'b0;
    upd_address_d = upd_address_q;
    upd_result_d  = upd_result_q;
    mispredict_d  = 1'b0;
    res_error_d   = empty_resolve;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
        upd_valid_d   = 1'b1;
        upd_address_d = head[ADDR_W:1];
        upd_result_d  = res_taken;
        mispredict_d  = head_wrong;
      end
      if (push && !pop) begin
        count_d = count_q + OCC_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - OCC_W'(1);
      end
    end
  end

  // Storage array register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control and output registers; reset wins over flush, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_address_q <= '0;
      upd_result_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      res_error_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_address_q <= upd_address_d;
      upd_result_q  <= upd_result_d;
      mispredict_q  <= mispredict_d;
      res_error_q   <= res_error_d;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_address = upd_address_q;
  assign upd_result  = upd_result_q;
  assign mispredict  = mispredict_q;
  assign res_error   = res_error_q;
  assign outstanding = count_q;

`ifdef BRU_MISPREDICT_COUNT_EN
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  // Saturating misprediction count; survives flush, cleared only by reset.
  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (pop && head_wrong && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  // Misprediction counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_cnt_q <= '0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign mispredict_count = mis_cnt_q;
`else
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pred_valid = 1'b0;
  logic [3:0] pred_addr = '0;
  logic       pred_taken = 1'b0;
  logic       pred_ready;
  logic       res_valid = 1'b0;
  logic       res_taken = 1'b0;
  logic       flush = 1'b0;
  logic       upd_valid;
  logic [3:0] upd_address;
  logic       upd_result;
  logic       mispredict;
  logic       res_error;
  logic [2:0] outstanding;
  logic [1:0] mispredict_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [4:0] mq [$];
  logic [4:0] hd;

  branch_resolve_unit #(.ADDR_W(4), .DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_address(upd_address), .upd_result(upd_result),
    .mispredict(mispredict), .res_error(res_error), .outstanding(outstanding),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp();
`ifdef BRU_MISPREDICT_COUNT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic bump();
    if (exp_cnt < 3) exp_cnt++;
  endtask

  task automatic cyc(input logic pv, input logic [3:0] pa, input logic pt,
                     input logic rv, input logic rt, input logic fl);
    pred_valid = pv; pred_addr = pa; pred_taken = pt;
    res_valid = rv; res_taken = rt; flush = fl;
    @(posedge clk);
    #1;
    pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_outstanding"}, 32'(outstanding), 0);
    check({tag, "_upd_valid"}, 32'(upd_valid), 0);
    check({tag, "_upd_address"}, 32'(upd_address), 0);
    check({tag, "_upd_result"}, 32'(upd_result), 0);
    check({tag, "_mispredict"}, 32'(mispredict), 0);
    check({tag, "_res_error"}, 32'(res_error), 0);
    check({tag, "_count"}, 32'(mispredict_count), 0);
    check({tag, "_pred_ready"}, 32'(pred_ready), 1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check_reset_state("rst");
    rst = 1'b0;

    // Single correct prediction
    cyc(1, 4'h0, 1, 0, 0, 0);
    check("push1_outstanding", 32'(outstanding), 1);
    check("push1_upd_valid", 32'(upd_valid), 0);
    cyc(0, 0, 0, 1, 1, 0);
    check("res1_upd_valid", 32'(upd_valid), 1);
    check("res1_upd_address", 32'(upd_address), 0);
    check("res1_upd_result", 32'(upd_result), 1);
    check("res1_mispredict", 32'(mispredict), 0);
    check("res1_outstanding", 32'(outstanding), 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("idle1_upd_valid", 32'(upd_valid), 0);
    check("idle1_upd_result_hold", 32'(upd_result), 1);

    // Single misprediction
    cyc(1, 4'h5, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    exp_cnt = 1;
    check("mis_mispredict", 32'(mispredict), 1);
    check("mis_upd_address", 32'(upd_address), 5);
    check("mis_count", 32'(mispredict_count), 32'(cnt_exp()));
    cyc(0, 0, 0, 0, 0, 0);
    check("mis_pulse_end", 32'(mispredict), 0);
    check("mis_addr_hold", 32'(upd_address), 5);

    // Fill to full, fifth push dropped, drain in order
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'(i + 1), i[0], 0, 0, 0);
      check($sformatf("fill_outstanding_%0d", i), 32'(outstanding), (i < 4) ? i + 1 : 4);
      check($sformatf("fill_ready_%0d", i), 32'(pred_ready), (i < 3) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      if (i[0]) bump();
      check($sformatf("drain_addr_%0d", i), 32'(upd_address), i + 1);
      check($sformatf("drain_mis_%0d", i), 32'(mispredict), 32'(i[0]));
      check($sformatf("drain_outstanding_%0d", i), 32'(outstanding), 3 - i);
      check($sformatf("drain_count_%0d", i), 32'(mispredict_count), 32'(cnt_exp()));
    end

    // Full queue: push+resolve rejects the push
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'(8 + i), 0, 0, 0, 0);
      mq.push_back({4'(8 + i), 1'b0});
    end
    hd = mq.pop_front();
    cyc(1, 4'hc, 1, 1, 0, 0);
    check("fullpp_addr", 32'(upd_address), 8);
    check("fullpp_outstanding", 32'(outstanding), 3);
    check("fullpp_ready", 32'(pred_ready), 1);
    hd = mq.pop_front();
    cyc(0, 0, 0, 1, 0, 0);
    check("pop9_addr", 32'(upd_address), 9);
    check("pop9_outstanding", 32'(outstanding), 2);

    // Ten simultaneous push+pop cycles at occupancy 2 wrap the pointers
    for (int j = 0; j < 10; j++) begin
      hd = mq.pop_front();
      cyc(1, 4'(j + 3), j[0], 1, hd[0], 0);
      mq.push_back({4'(j + 3), j[0]});
      check($sformatf("wrap_addr_%0d", j), 32'(upd_address), 32'(hd[4:1]));
      check($sformatf("wrap_result_%0d", j), 32'(upd_result), 32'(hd[0]));
      check($sformatf("wrap_mis_%0d", j), 32'(mispredict), 0);
      check($sformatf("wrap_outstanding_%0d", j), 32'(outstanding), 2);
    end
    for (int j = 0; j < 2; j++) begin
      hd = mq.pop_front();
      cyc(0, 0, 0, 1, hd[0], 0);
      check($sformatf("wrapdrain_addr_%0d", j), 32'(upd_address), 32'(hd[4:1]));
    end
    check("wrapdrain_outstanding", 32'(outstanding), 0);

    // Resolve with empty queue
    cyc(0, 0, 0, 1, 1, 0);
    check("empty_res_error", 32'(res_error), 1);
    check("empty_upd_valid", 32'(upd_valid), 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("empty_res_error_end", 32'(res_error), 0);
    cyc(1, 4'h6, 1, 1, 1, 0);
    check("emptypush_res_error", 32'(res_error), 1);
    check("emptypush_upd_valid", 32'(upd_valid), 0);
    check("emptypush_outstanding", 32'(outstanding), 1);
    cyc(0, 0, 0, 1, 1, 0);
    check("emptypush_pop_addr", 32'(upd_address), 6);

    // Flush with three outstanding, same-cycle push and resolve suppressed
    for (int i = 0; i < 3; i++) cyc(1, 4'(1 + i), 1, 0, 0, 0);
    check("preflush_outstanding", 32'(outstanding), 3);
    cyc(1, 4'hf, 0, 1, 0, 1);
    check("flush_outstanding", 32'(outstanding), 0);
    check("flush_upd_valid", 32'(upd_valid), 0);
    check("flush_res_error", 32'(res_error), 0);
    check("flush_count", 32'(mispredict_count), 32'(cnt_exp()));
    check("flush_ready", 32'(pred_ready), 1);
    cyc(1, 4'h7, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("postflush_addr", 32'(upd_address), 7);
    check("postflush_mis", 32'(mispredict), 0);

    // Reset mid-stream discards entries
    cyc(1, 4'h2, 1, 0, 0, 0);
    cyc(1, 4'h3, 1, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 4'h4, 1, 1, 0, 0);
    check_reset_state("midrst");
    rst = 1'b0;
    exp_cnt = 0;
    cyc(0, 0, 0, 1, 1, 0);
    check("midrst_res_error", 32'(res_error), 1);
    check("midrst_upd_valid", 32'(upd_valid), 0);

    // Counter saturation at 3 with CNT_W=2
    for (int k = 0; k < 5; k++) begin
      cyc(1, 4'(k), 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0);
      bump();
      check($sformatf("sat_mis_%0d", k), 32'(mispredict), 1);
      check($sformatf("sat_count_%0d", k), 32'(mispredict_count), 32'(cnt_exp()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
